uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//   Parametrised UART receiver; successor to the fixed 8-bit, 2-clock/bit receiver front end.
//   Oversampled mid-bit sampling, optional parity, 1 or 2 stop bits, framing/parity/overrun detection.
//   One-word output buffer with valid/ready handshake feeding the command decoder / 7-seg logic.
// PARAMETERS
//   CLKS_PER_BIT  16  clocks per bit period; >=4; mid-bit sample at CLKS_PER_BIT/2
//   DATA_BITS     8   payload bits per frame, 5..9, LSB first
//   PARITY_EN     0   1 = parity bit follows data
//   PARITY_ODD    0   1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//   STOP_BITS     1   1 or 2; every stop bit is checked
// PORTS
//   clock       in   1          system clock, all logic on posedge
//   reset       in   1          synchronous, active-high
//   serial      in   1          async RX line, idle high
//   data_out    out  DATA_BITS  received word, stable while data_valid=1
//   data_valid  out  1          word in buffer
//   data_ready  in   1          consumer accepts; transfer when valid&&ready
//   frame_err   out  1          sticky with word: a stop bit sampled 0
//   parity_err  out  1          sticky with word: parity mismatch
//   overrun     out  1          1-cycle pulse: frame completed while buffer full
//   busy        out  1          1 while FSM not in IDLE
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; synchroniser flops=1; counters=0. Reset mid-frame aborts the frame.
//   Input: serial through 2-FF synchroniser (rx_s); 2-cycle latency, no further filtering.
//   FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
//     IDLE : rx_s==0 -> START, baud_cnt=0.
//     START: at baud_cnt==CLKS_PER_BIT/2-1 sample; 0 -> DATA, bit_idx=0, baud_cnt=0; 1 -> IDLE (glitch, no flags).
//     DATA : sample at baud_cnt==CLKS_PER_BIT-1 (mid-bit); shift into sh[bit_idx]; after bit DATA_BITS-1 -> PARITY
//            if PARITY_EN else STOP.
//     PARITY: sample once; par_bad = ^sh ^ bit ^ PARITY_ODD.
//     STOP : sample STOP_BITS times; any 0 sets fr_bad. After last stop sample -> commit (below), then
//            IDLE if last sample 1, else BREAK.
//     BREAK: wait for rx_s==1, then IDLE (line held low must not retrigger start).
//   baud_cnt wraps to 0 at each sample point; width $clog2(CLKS_PER_BIT).
//   Commit (cycle after last stop sample), output buffer:
//     buffer empty, or valid&&ready same cycle -> load data_out/frame_err/parity_err; data_valid=1.
//     buffer full and !ready -> new frame dropped, old word kept, overrun=1 for 1 cycle.
//   Handshake: valid&&ready with no commit -> data_valid=0 next cycle; data_out holds last value;
//     error flags cleared. data_ready ignored while data_valid=0.
//   Errored frames are still delivered, with their flag(s) set.
//   Latency: data_valid rises 1 clock after mid-point of last stop bit (+2 synchroniser cycles from line).
//   busy = (state!=IDLE).
// STRUCTURE
//   uart_pkg: rx_state_t enum, UART_IDLE_LVL=1'b1, function parity_calc(data, odd).
//   Sub-module uart_rx_sync: 2-FF synchroniser, reset value 1.
//   FSM, baud counter, shifter and output buffer stay in uart_rx_param.
// TESTING
//   Defaults, send 0xA5 8N1 -> data_out=0xA5, valid 1 clk after stop mid-point, no flags.
//   DATA_BITS=7, PARITY_EN=1, ODD=0: send 0x41 with parity 0 -> parity_err=0; parity 1 -> parity_err=1, data 0x41.
//   Stop bit 0 then line low 40 bit-times -> frame_err=1, single word, state BREAK until line high, no 2nd frame.
//   Low pulse of CLKS_PER_BIT/4 clocks in IDLE -> back to IDLE, no valid, no flags.
//   Two frames (0x11, 0x22), ready=0 -> data_out=0x11 retained, overrun pulses 1 clk; ready at commit -> 0x22 loaded.
//   reset asserted mid-DATA -> next clock all outputs 0, busy=0; next 0x3C frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int   MAX_DATA_BITS = 9;

    // Expected parity bit for a (zero-extended) payload.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX line; powers up at the idle level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= UART_IDLE_LVL;
            sync_p1 <= UART_IDLE_LVL;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    assign dout = sync_p1;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity/framing/overrun detection
// and a single-word valid/ready output buffer.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clock (clock),
        .reset (reset),
        .din   (serial),
        .dout  (rx_s)
    );

    rx_state_t      state, state_nxt;
    logic [CW-1:0]  baud_cnt, baud_nxt;
    logic [BW-1:0]  bit_idx, bit_nxt;
    logic           stop_idx, stop_nxt;
    logic           frame_clr, samp_data, samp_par, samp_stop, stop_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            stop_idx <= stop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        stop_nxt  = stop_idx;
        frame_clr = 1'b0;
        samp_data = 1'b0;
        samp_par  = 1'b0;
        samp_stop = 1'b0;
        stop_last = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                // Re-check the start bit at its midpoint to reject short glitches.
                if (baud_cnt == HALF_CNT) begin
                    baud_nxt = '0;
                    if (!rx_s) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                        frame_clr = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_cnt == FULL_CNT) begin
                    baud_nxt  = '0;
                    samp_data = 1'b1;
                    bit_nxt   = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_nxt  = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (baud_cnt == FULL_CNT) begin
                    baud_nxt  = '0;
                    samp_par  = 1'b1;
                    state_nxt = STOP;
                    stop_nxt  = 1'b0;
                end
            end
            STOP: begin
                if (baud_cnt == FULL_CNT) begin
                    baud_nxt  = '0;
                    samp_stop = 1'b1;
                    stop_nxt  = stop_idx + 1'b1;
                    if (stop_idx == LAST_STOP) begin
                        stop_last = 1'b1;
                        // A low final stop bit means the line is held low: park until it recovers.
                        state_nxt = rx_s ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                baud_nxt = '0;
                if (rx_s) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Frame accumulation: payload shifts in LSB first from the top.
    logic [DATA_BITS-1:0] sh;
    logic                 fr_bad;
    logic                 par_bad;

    always_ff @(posedge clock) begin
        if (frame_clr) begin
            fr_bad  <= 1'b0;
            par_bad <= 1'b0;
        end
        if (samp_data) sh <= {rx_s, sh[DATA_BITS-1:1]};
        if (samp_par)  par_bad <= parity_calc(MAX_DATA_BITS'(sh), 1'(PARITY_ODD)) ^ rx_s;
        if (samp_stop && !rx_s) fr_bad <= 1'b1;
    end

    // Stage p1: committed frame, one cycle after the last stop sample.
    logic                 vld_p1;
    logic [DATA_BITS-1:0] word_p1;
    logic                 fe_p1;
    logic                 pe_p1;

    always_ff @(posedge clock) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= stop_last;
    end

    always_ff @(posedge clock) begin
        if (stop_last) begin
            word_p1 <= sh;
            fe_p1   <= fr_bad | ~rx_s;
            pe_p1   <= par_bad;
        end
    end

    // Stage p2: output buffer; a full buffer drops the new frame and flags overrun.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (vld_p1) begin
                if (!data_valid || data_ready) begin
                    data_out   <= word_p1;
                    data_valid <= 1'b1;
                    frame_err  <= fe_p1;
                    parity_err <= pe_p1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed scoreboard bench for uart_rx_param: an 8N1 receiver and a 7E1 receiver.
module tb_uart_rx_param;

    localparam int CPB_A = 16;
    localparam int CPB_B = 8;

    logic       clock;
    logic       reset;
    logic       ser_a, ser_b;
    logic       rdy_a, rdy_b;
    logic [7:0] do_a;
    logic [6:0] do_b;
    logic       dv_a, fe_a, pe_a, ov_a, busy_a;
    logic       dv_b, fe_b, pe_b, ov_b, busy_b;

    uart_rx_param #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8), .PARITY_EN(0),
                    .PARITY_ODD(0), .STOP_BITS(1)) u_a (
        .clock      (clock),
        .reset      (reset),
        .serial     (ser_a),
        .data_out   (do_a),
        .data_valid (dv_a),
        .data_ready (rdy_a),
        .frame_err  (fe_a),
        .parity_err (pe_a),
        .overrun    (ov_a),
        .busy       (busy_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(7), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(1)) u_b (
        .clock      (clock),
        .reset      (reset),
        .serial     (ser_b),
        .data_out   (do_b),
        .data_valid (dv_b),
        .data_ready (rdy_b),
        .frame_err  (fe_b),
        .parity_err (pe_b),
        .overrun    (ov_b),
        .busy       (busy_b)
    );

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ovr_a = 0;
    int   ovr_b = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_bit(input bit which, input logic v, input int cpb);
        if (which) ser_b = v;
        else       ser_a = v;
        tick(cpb);
    endtask

    task automatic send_head(input bit which, input logic [8:0] d, input int nb,
                             input bit pen, input logic par);
        int cpb;
        cpb = which ? CPB_B : CPB_A;
        drive_bit(which, 1'b0, cpb);
        for (int i = 0; i < nb; i++) drive_bit(which, d[i], cpb);
        if (pen) drive_bit(which, par, cpb);
    endtask

    task automatic send_frame(input bit which, input logic [8:0] d, input int nb,
                              input bit pen, input logic par, input logic stopv);
        send_head(which, d, nb, pen, par);
        drive_bit(which, stopv, which ? CPB_B : CPB_A);
    endtask

    // Scoreboard monitors: every accepted word is popped and compared.
    always @(negedge clock) begin : mon_a
        exp_t e;
        if (ov_a) ovr_a++;
        if (dv_a && rdy_a) begin
            n_vec++;
            assert (q_a.size() != 0) else begin
                n_err++;
                $error("FAIL a_spurious_word observed=%0h expected=none", do_a);
            end
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                chk("a_data", 32'(do_a), 32'(e.d));
                chk("a_frame_err", 32'(fe_a), 32'(e.fe));
                chk("a_parity_err", 32'(pe_a), 32'(e.pe));
            end
        end
    end

    always @(negedge clock) begin : mon_b
        exp_t e;
        if (ov_b) ovr_b++;
        if (dv_b && rdy_b) begin
            n_vec++;
            assert (q_b.size() != 0) else begin
                n_err++;
                $error("FAIL b_spurious_word observed=%0h expected=none", do_b);
            end
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                chk("b_data", 32'(do_b), 32'(e.d));
                chk("b_frame_err", 32'(fe_b), 32'(e.fe));
                chk("b_parity_err", 32'(pe_b), 32'(e.pe));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        ser_a = 1'b1;
        ser_b = 1'b1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        tick(5);
        chk("rst_data_out", 32'(do_a), 32'h0);
        chk("rst_valid", 32'(dv_a), 32'h0);
        chk("rst_frame_err", 32'(fe_a), 32'h0);
        chk("rst_parity_err", 32'(pe_a), 32'h0);
        chk("rst_overrun", 32'(ov_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_b_valid", 32'(dv_b), 32'h0);
        chk("rst_b_busy", 32'(busy_b), 32'h0);
        reset = 1'b0;
        tick(5);

        // 0xA5 8N1: last stop midpoint sampled 155 clocks after start edge, valid one clock later.
        q_a.push_back('{9'h0A5, 1'b0, 1'b0});
        send_head(1'b0, 9'h0A5, 8, 1'b0, 1'b0);
        ser_a = 1'b1;
        tick(11);
        chk("a5_valid_early", 32'(dv_a), 32'h0);
        tick(1);
        chk("a5_valid", 32'(dv_a), 32'h1);
        chk("a5_data", 32'(do_a), 32'hA5);
        chk("a5_frame_err", 32'(fe_a), 32'h0);
        chk("a5_parity_err", 32'(pe_a), 32'h0);
        tick(4);
        rdy_a = 1'b1;
        tick(1);
        rdy_a = 1'b0;
        chk("a5_drained", 32'(dv_a), 32'h0);
        chk("a5_data_hold", 32'(do_a), 32'hA5);

        // Short low glitch in IDLE.
        ser_a = 1'b0;
        tick(CPB_A / 4);
        ser_a = 1'b1;
        tick(2);
        chk("glitch_busy", 32'(busy_a), 32'h1);
        tick(30);
        chk("glitch_idle", 32'(busy_a), 32'h0);
        chk("glitch_valid", 32'(dv_a), 32'h0);
        chk("glitch_frame_err", 32'(fe_a), 32'h0);
        chk("glitch_overrun_cnt", 32'(ovr_a), 32'h0);

        // Stop bit low, line held low for 40 bit-times.
        q_a.push_back('{9'h05A, 1'b1, 1'b0});
        send_head(1'b0, 9'h05A, 8, 1'b0, 1'b0);
        ser_a = 1'b0;
        tick(CPB_A * 40);
        chk("brk_valid", 32'(dv_a), 32'h1);
        chk("brk_data", 32'(do_a), 32'h5A);
        chk("brk_frame_err", 32'(fe_a), 32'h1);
        chk("brk_parity_err", 32'(pe_a), 32'h0);
        chk("brk_busy", 32'(busy_a), 32'h1);
        ser_a = 1'b1;
        tick(4);
        chk("brk_released", 32'(busy_a), 32'h0);
        tick(CPB_A * 12);
        chk("brk_no_second_frame", 32'(ovr_a), 32'h0);
        chk("brk_still_valid", 32'(dv_a), 32'h1);
        rdy_a = 1'b1;
        tick(1);
        rdy_a = 1'b0;
        chk("brk_drained", 32'(dv_a), 32'h0);
        chk("brk_flag_cleared", 32'(fe_a), 32'h0);

        // Two frames with ready low: second one dropped with an overrun pulse.
        q_a.push_back('{9'h011, 1'b0, 1'b0});
        send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1);
        send_head(1'b0, 9'h022, 8, 1'b0, 1'b0);
        ser_a = 1'b1;
        tick(11);
        chk("ovr_before", 32'(ov_a), 32'h0);
        tick(1);
        chk("ovr_pulse", 32'(ov_a), 32'h1);
        chk("ovr_retained", 32'(do_a), 32'h11);
        tick(1);
        chk("ovr_one_cycle", 32'(ov_a), 32'h0);
        tick(3);
        // Third frame: ready asserted on the commit cycle swaps in the new word.
        q_a.push_back('{9'h022, 1'b0, 1'b0});
        send_head(1'b0, 9'h022, 8, 1'b0, 1'b0);
        ser_a = 1'b1;
        tick(11);
        rdy_a = 1'b1;
        tick(1);
        rdy_a = 1'b0;
        chk("swap_data", 32'(do_a), 32'h22);
        chk("swap_valid", 32'(dv_a), 32'h1);
        chk("swap_no_overrun", 32'(ov_a), 32'h0);
        chk("ovr_total", 32'(ovr_a), 32'h1);
        tick(4);

        // Reset in the middle of a 0x3C frame; buffered 0x22 is discarded.
        drive_bit(1'b0, 1'b0, CPB_A);
        drive_bit(1'b0, 1'b0, CPB_A);
        drive_bit(1'b0, 1'b0, CPB_A);
        drive_bit(1'b0, 1'b1, CPB_A);
        chk("mid_busy", 32'(busy_a), 32'h1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_data_out", 32'(do_a), 32'h0);
        chk("mid_rst_valid", 32'(dv_a), 32'h0);
        chk("mid_rst_frame_err", 32'(fe_a), 32'h0);
        chk("mid_rst_parity_err", 32'(pe_a), 32'h0);
        chk("mid_rst_overrun", 32'(ov_a), 32'h0);
        chk("mid_rst_busy", 32'(busy_a), 32'h0);
        q_a.delete();
        reset = 1'b0;
        ser_a = 1'b1;
        tick(CPB_A * 12);
        q_a.push_back('{9'h03C, 1'b0, 1'b0});
        send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b1);
        chk("3c_valid", 32'(dv_a), 32'h1);
        chk("3c_data", 32'(do_a), 32'h3C);
        rdy_a = 1'b1;
        tick(1);
        rdy_a = 1'b0;

        // 7E1: 0x41 has two ones, so parity bit 0 is good and 1 is bad.
        q_b.push_back('{9'h041, 1'b0, 1'b0});
        send_frame(1'b1, 9'h041, 7, 1'b1, 1'b0, 1'b1);
        tick(4);
        chk("par_ok_valid", 32'(dv_b), 32'h1);
        chk("par_ok_flag", 32'(pe_b), 32'h0);
        rdy_b = 1'b1;
        tick(1);
        rdy_b = 1'b0;
        q_b.push_back('{9'h041, 1'b0, 1'b1});
        send_frame(1'b1, 9'h041, 7, 1'b1, 1'b1, 1'b1);
        tick(4);
        chk("par_bad_flag", 32'(pe_b), 32'h1);
        chk("par_bad_data", 32'(do_b), 32'h41);
        chk("par_bad_frame_err", 32'(fe_b), 32'h0);
        rdy_b = 1'b1;
        tick(1);
        rdy_b = 1'b0;
        chk("par_flag_cleared", 32'(pe_b), 32'h0);
        chk("b_overrun_cnt", 32'(ovr_b), 32'h0);

        tick(5);
        chk("a_queue_empty", 32'(q_a.size()), 32'h0);
        chk("b_queue_empty", 32'(q_b.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
